// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Brief    : Synchronised, glitch-filtered quadrature decoder producing step /
//            direction strobes with illegal-transition detection and counting.
// Revision : 1.0
// ============================================================================
module quadrature_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             en,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int INIT_LEN = FILTER_LEN + 2;
    localparam int CNT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int INIT_W   = $clog2(INIT_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FILTER_LEN - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic             a_m, a_s, b_m, b_s;
    logic             a_f, b_f;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic [INIT_W-1:0] init_cnt;
    logic [1:0]       prev;
    logic [1:0]       cur;
    logic             init_last;
    logic             is_up, is_down, is_dbl;
    logic             step_d, err_d, dir_d;

    assign cur       = {a_f, b_f};
    assign init_last = (init_cnt == INIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        is_up      = 1'b0;
        is_down    = 1'b0;
        is_dbl     = 1'b0;
        step_d     = 1'b0;
        err_d      = 1'b0;
        dir_d      = up_down;
        case (state)
            ST_INIT: begin
                if (init_last) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Transition table indexed by {prev, cur}; Gray order 00-01-11-10 is up.
                case ({prev, cur})
                    4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: is_up   = 1'b1;
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_down = 1'b1;
                    4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: is_dbl  = 1'b1;
                    default: ;
                endcase
                step_d = en & (is_up | is_down);
                err_d  = en & is_dbl;
                if (step_d) begin
                    dir_d = is_up;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_m       <= 1'b0;
            a_s       <= 1'b0;
            b_m       <= 1'b0;
            b_s       <= 1'b0;
            a_f       <= 1'b0;
            b_f       <= 1'b0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            init_cnt  <= '0;
            prev      <= 2'b00;
            step      <= 1'b0;
            err       <= 1'b0;
            up_down   <= 1'b1;
            err_count <= '0;
        end else begin
            a_m     <= quad_a;
            a_s     <= a_m;
            b_m     <= quad_b;
            b_s     <= b_m;
            step    <= step_d;
            err     <= err_d;
            up_down <= dir_d;
            if (err_d && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end

            if (state == ST_INIT) begin
                // Filter bypassed while the pins settle so RUN starts from the true level.
                a_f      <= a_s;
                b_f      <= b_s;
                cnt_a    <= '0;
                cnt_b    <= '0;
                init_cnt <= init_cnt + INIT_W'(1);
                if (init_last) begin
                    prev <= {a_s, b_s};
                end
            end else begin
                prev <= cur;

                if (a_s == a_f) begin
                    cnt_a <= '0;
                end else if (cnt_a == CNT_MAX) begin
                    a_f   <= a_s;
                    cnt_a <= '0;
                end else begin
                    cnt_a <= cnt_a + CNT_W'(1);
                end

                if (b_s == b_f) begin
                    cnt_b <= '0;
                end else if (cnt_b == CNT_MAX) begin
                    b_f   <= b_s;
                    cnt_b <= '0;
                end else begin
                    cnt_b <= cnt_b + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder
// Brief    : Directed bench for quadrature_decoder with a per-cycle reference
//            model and hand-computed checkpoint expectations.
// Revision : 1.0
// ============================================================================
module tb_quadrature_decoder;

    localparam int FL       = 4;
    localparam int EW       = 8;
    localparam int INIT_LEN = FL + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          quad_a = 1'b0;
    logic          quad_b = 1'b0;
    logic          en = 1'b1;
    logic          step;
    logic          up_down;
    logic          err;
    logic [EW-1:0] err_count;

    int total = 0;
    int bad   = 0;

    quadrature_decoder #(.FILTER_LEN(FL), .ERR_W(EW)) dut (
        .clk       (clk),
        .reset     (reset),
        .quad_a    (quad_a),
        .quad_b    (quad_b),
        .en        (en),
        .step      (step),
        .up_down   (up_down),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Reference model: pins seen two samples late, a level is accepted once it
    // has persisted FL samples, events come from Gray-position differences.
    logic p_reset = 1'b1, p_a = 1'b0, p_b = 1'b0, p_en = 1'b1;
    logic m_s1a, m_s2a, m_s1b, m_s2b, m_af, m_bf;
    logic m_step, m_err, m_ud;
    logic [1:0] m_prev;
    logic m_init;
    logic as_v, bs_v;
    int   m_runa, m_runb, m_since, m_cnt, d;

    int step_cnt = 0;
    int err_cnt  = 0;
    int ctr      = 0;

    function automatic int gpos(input logic a, input logic b);
        logic [1:0] p;
        p = {a, a ^ b};
        return int'(p);
    endfunction

    always @(negedge clk) begin
        if (p_reset) begin
            m_s1a = 0; m_s2a = 0; m_s1b = 0; m_s2b = 0;
            m_af = 0; m_bf = 0; m_runa = 0; m_runb = 0;
            m_since = 0; m_init = 1; m_prev = 2'b00;
            m_step = 0; m_err = 0; m_ud = 1; m_cnt = 0;
        end else begin
            as_v = m_s2a;
            bs_v = m_s2b;
            if (m_init) begin
                m_step = 0;
                m_err  = 0;
                if (m_since == INIT_LEN - 1) begin
                    m_prev = {as_v, bs_v};
                    m_init = 0;
                end
                m_since++;
                m_af = as_v;
                m_bf = bs_v;
            end else begin
                d = (gpos(m_af, m_bf) - gpos(m_prev[1], m_prev[0])) & 3;
                m_step = p_en && (d == 1 || d == 3);
                m_err  = p_en && (d == 2);
                if (m_step) m_ud = (d == 1);
                if (m_err && m_cnt < (2**EW - 1)) m_cnt++;
                m_prev = {m_af, m_bf};
                m_runa = (as_v != m_af) ? m_runa + 1 : 0;
                if (m_runa == FL) begin m_af = as_v; m_runa = 0; end
                m_runb = (bs_v != m_bf) ? m_runb + 1 : 0;
                if (m_runb == FL) begin m_bf = bs_v; m_runb = 0; end
            end
            m_s2a = m_s1a; m_s1a = p_a;
            m_s2b = m_s1b; m_s1b = p_b;
        end

        total++;
        if ({step, err, up_down, err_count} !== {m_step, m_err, m_ud, EW'(m_cnt)}) begin
            bad++;
            $display("FAIL cycle_model t=%0t: dut step=%b err=%b ud=%b cnt=%0d, model step=%b err=%b ud=%b cnt=%0d",
                     $time, step, err, up_down, err_count, m_step, m_err, m_ud, m_cnt);
        end

        if (step === 1'b1) begin
            step_cnt++;
            ctr = up_down ? ctr + 1 : ctr - 1;
        end
        if (err === 1'b1) err_cnt++;

        p_reset = reset; p_a = quad_a; p_b = quad_b; p_en = en;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b);
        @(posedge clk);
        #1;
        quad_a = a;
        quad_b = b;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        // 1: reset with A=B=1, then idle
        quad_a = 1; quad_b = 1; reset = 1;
        hold(3);
        #1 reset = 0;
        hold(20);
        settle();
        chk("t1_steps", step_cnt, 0);
        chk("t1_errs", err_cnt, 0);
        chk("t1_up_down", int'(up_down), 1);
        chk("t1_err_count", int'(err_count), 0);

        // re-initialise with pins at 00
        drive(0, 0);
        #1 reset = 1;
        hold(3);
        #1 reset = 0;
        hold(15);
        step_cnt = 0; err_cnt = 0; ctr = 0;

        // 2: four up steps
        drive(0, 1);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin lat = i; break; end
        end
        chk("t2_latency", lat, 7);
        hold(5);
        drive(1, 1); hold(12);
        drive(1, 0); hold(12);
        drive(0, 0); hold(12);
        settle();
        chk("t2_steps", step_cnt, 4);
        chk("t2_up_down", int'(up_down), 1);
        chk("t2_counter", ctr, 4);

        // 3: three down steps
        step_cnt = 0;
        drive(1, 0);
        hold(7);
        #1;
        chk("t3_first_step", int'(step), 1);
        chk("t3_first_ud", int'(up_down), 0);
        hold(5);
        drive(1, 1); hold(12);
        drive(0, 1); hold(12);
        settle();
        chk("t3_steps", step_cnt, 3);
        chk("t3_counter", ctr, 1);

        // 4: glitch filter boundary
        step_cnt = 0;
        drive(1, 1); hold(2);
        drive(0, 1); hold(15);
        settle();
        chk("t4_short_pulse", step_cnt, 0);
        drive(1, 1); hold(3);
        drive(0, 1); hold(15);
        settle();
        chk("t4_long_pulse", step_cnt, 2);
        chk("t4_counter", ctr, 1);
        chk("t4_up_down", int'(up_down), 0);

        // 5: double transitions and saturation
        drive(0, 0); hold(12);
        step_cnt = 0; err_cnt = 0;
        drive(1, 1); hold(12);
        settle();
        chk("t5_err_count_1", int'(err_count), 1);
        chk("t5_err_pulses_1", err_cnt, 1);
        chk("t5_no_step", step_cnt, 0);
        chk("t5_ud_kept", int'(up_down), 0);
        for (int i = 0; i < 299; i++) begin
            if (i % 2 == 0) drive(0, 0);
            else            drive(1, 1);
            hold(5);
        end
        hold(12);
        settle();
        chk("t5_err_count_sat", int'(err_count), 255);
        chk("t5_err_pulses", err_cnt, 300);
        chk("t5_steps", step_cnt, 0);

        // 6: enable gating, then reset mid-stream
        @(posedge clk);
        #1 en = 0;
        step_cnt = 0; err_cnt = 0;
        drive(1, 0); hold(12);
        settle();
        chk("t6_disabled_step", step_cnt, 0);
        @(posedge clk);
        #1 en = 1;
        hold(12);
        settle();
        chk("t6_reenable_step", step_cnt, 0);
        chk("t6_reenable_err", err_cnt, 0);
        chk("t6_cnt_frozen", int'(err_count), 255);
        drive(1, 1); hold(3);
        #1 reset = 1;
        hold(3);
        #1;
        chk("t6_reset_err_count", int'(err_count), 0);
        chk("t6_reset_up_down", int'(up_down), 1);
        reset = 0;
        hold(20);
        settle();
        chk("t6_dropped_step", step_cnt, 0);
        chk("t6_after_reset_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
